// File: rtl/pipeline_pkg.sv
// Shared pipeline types and defaults: fetch FSM state encoding and
// the address/data widths and reset PC used by the fetch front end.
`default_nettype none

package pipeline_pkg;

  localparam int PIPE_ADDR_W = 32;
  localparam int PIPE_DATA_W = 32;
  localparam logic [PIPE_ADDR_W-1:0] PIPE_RESET_PC = '0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_hold_buf.sv
// Single-entry skid register that parks a fetched instruction and its PC
// while the IF/ID stage is stalled.
`default_nettype none

module fetch_hold_buf
  import pipeline_pkg::*;
#(
  parameter int ADDR_W = PIPE_ADDR_W,
  parameter int DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_pc
);

  logic              r_valid;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_pc;

  // Load has priority so a same-cycle clear cannot lose a fresh capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the fetch PC, runs the imem req/ready
// handshake, and applies stalls, branch/jump redirects and pipeline flushes.
`default_nettype none

module fetch_controller
  import pipeline_pkg::*;
#(
  parameter int                ADDR_W   = PIPE_ADDR_W,
  parameter int                DATA_W   = PIPE_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PIPE_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              flush_if_id,
  output logic              flush_id_ex
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_squash;
  logic [ADDR_W-1:0] r_pend_target;

  logic              w_redirect;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_buf_load;
  logic              w_buf_clear;
  logic              w_buf_valid;
  logic [DATA_W-1:0] w_buf_instr;
  logic [ADDR_W-1:0] w_buf_pc;

  assign w_redirect  = branch_taken | jump;
  assign w_target    = branch_taken ? branch_target : jump_target;
  assign w_pc_inc    = r_pc + ADDR_W'(1);
  assign flush_if_id = w_redirect;
  assign flush_id_ex = branch_taken;
  assign imem_addr   = r_pc;

  fetch_hold_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .o_valid (w_buf_valid),
    .o_instr (w_buf_instr),
    .o_pc    (w_buf_pc)
  );

  always_comb begin
    imem_req    = 1'b0;
    if_valid    = 1'b0;
    if_instr    = imem_rdata;
    if_pc       = r_pc;
    w_buf_load  = 1'b0;
    w_buf_clear = 1'b0;
    case (r_state)
      FETCH: begin
        imem_req = !stall;
        if_valid = !stall && imem_ready && !w_redirect;
      end
      WAIT: begin
        // Request stays up through stalls; a stalled return is parked.
        imem_req = 1'b1;
        if (imem_ready && !r_squash && !w_redirect) begin
          if_valid   = !stall;
          w_buf_load = stall;
        end
      end
      HOLD: begin
        if_instr = w_buf_instr;
        if_pc    = w_buf_pc;
        if (w_redirect) begin
          w_buf_clear = 1'b1;
        end else if (!stall) begin
          if_valid    = w_buf_valid;
          w_buf_clear = 1'b1;
        end
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_squash      <= 1'b0;
      r_pend_target <= '0;
    end else begin
      case (r_state)
        BOOT: r_state <= FETCH;
        FETCH: begin
          if (stall) begin
            if (w_redirect) r_pc <= w_target;
          end else if (imem_ready) begin
            r_pc <= w_redirect ? w_target : w_pc_inc;
          end else begin
            // Request issued but not returned: the word in flight is squashed
            // later if a redirect arrived alongside it.
            r_state       <= WAIT;
            r_squash      <= w_redirect;
            r_pend_target <= w_target;
          end
        end
        WAIT: begin
          if (!imem_ready) begin
            if (w_redirect) begin
              r_squash      <= 1'b1;
              r_pend_target <= w_target;
            end
          end else if (r_squash || w_redirect) begin
            r_pc     <= w_redirect ? w_target : r_pend_target;
            r_squash <= 1'b0;
            r_state  <= FETCH;
          end else begin
            r_pc    <= w_pc_inc;
            r_state <= stall ? HOLD : FETCH;
          end
        end
        HOLD: begin
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= FETCH;
          end else if (!stall) begin
            r_state <= FETCH;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios with literal
// expectations plus randomized traffic checked against a transaction model.
`default_nettype none

module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush_if_id;
  logic        flush_id_ex;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_controller #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: tracks the PC, whether a memory request is in
  // flight (and whether its word is to be thrown away), and a parked word.
  bit          m_boot = 1'b1;
  bit          m_inflight = 1'b0;
  bit          m_discard = 1'b0;
  logic [31:0] m_discard_tgt = '0;
  bit          m_parked = 1'b0;
  logic [31:0] m_park_instr = '0;
  logic [31:0] m_park_pc = '0;
  logic [31:0] m_pc = '0;

  always @(negedge clk) begin
    bit          redir;
    logic [31:0] tgt;
    bit          e_req;
    bit          e_val;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    #2;
    redir   = branch_taken | jump;
    tgt     = branch_taken ? branch_target : jump_target;
    e_req   = 1'b0;
    e_val   = 1'b0;
    e_instr = '0;
    e_pc    = '0;
    if (rst) begin
      m_boot = 1; m_inflight = 0; m_discard = 0; m_parked = 0; m_pc = '0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_parked) begin
      if (redir) begin
        m_parked = 0; m_pc = tgt;
      end else if (!stall) begin
        e_val = 1; e_instr = m_park_instr; e_pc = m_park_pc; m_parked = 0;
      end
    end else if (m_inflight) begin
      e_req = 1;
      if (!imem_ready) begin
        if (redir) begin m_discard = 1; m_discard_tgt = tgt; end
      end else begin
        m_inflight = 0;
        if (m_discard || redir) begin
          m_pc = redir ? tgt : m_discard_tgt;
          m_discard = 0;
        end else if (!stall) begin
          e_val = 1; e_instr = imem_rdata; e_pc = m_pc; m_pc = m_pc + 1;
        end else begin
          m_parked = 1; m_park_instr = imem_rdata; m_park_pc = m_pc; m_pc = m_pc + 1;
        end
      end
    end else begin
      e_req = !stall;
      if (stall) begin
        if (redir) m_pc = tgt;
      end else if (imem_ready) begin
        if (redir) m_pc = tgt;
        else begin e_val = 1; e_instr = imem_rdata; e_pc = m_pc; m_pc = m_pc + 1; end
      end else begin
        m_inflight = 1; m_discard = redir; m_discard_tgt = tgt;
      end
    end
    chk("m_flush_if_id", 32'(flush_if_id), 32'(redir));
    chk("m_flush_id_ex", 32'(flush_id_ex), 32'(branch_taken));
    chk("m_imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("m_imem_addr", imem_addr, e_req ? (e_val || !e_val ? imem_addr_exp(e_val, e_pc) : 0) : 0);
    chk("m_if_valid", 32'(if_valid), 32'(e_val));
    if (e_val) begin
      chk("m_if_instr", if_instr, e_instr);
      chk("m_if_pc", if_pc, e_pc);
    end
  end

  // The address shown while a request is up is the PC before this cycle's
  // update; a delivered word carries that same PC.
  logic [31:0] m_addr_now;
  always @(negedge clk) m_addr_now <= m_pc;
  function automatic logic [31:0] imem_addr_exp(input bit v, input logic [31:0] p);
    return v ? p : m_addr_now;
  endfunction

  task automatic drive(input bit s, input bit bt, input logic [31:0] btg,
                       input bit j, input logic [31:0] jt, input bit rdy);
    @(negedge clk);
    rst           = 1'b0;
    stall         = s;
    branch_taken  = bt;
    branch_target = btg;
    jump          = j;
    jump_target   = jt;
    imem_ready    = rdy;
    imem_rdata    = $urandom;
    #1;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);

    drive(0, 0, 0, 0, 0, 1);
    chk("boot_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      chk("seq_addr", imem_addr, 32'(i));
      chk("seq_valid", 32'(if_valid), 32'd1);
      chk("seq_pc", if_pc, 32'(i));
    end
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 32'h40, 1, 32'h99, 1);
    chk("br_addr", imem_addr, 32'd5);
    chk("br_flush_if_id", 32'(flush_if_id), 32'd1);
    chk("br_flush_id_ex", 32'(flush_id_ex), 32'd1);
    chk("br_valid", 32'(if_valid), 32'd0);
    drive(0, 0, 0, 0, 0, 1);
    chk("br_next_addr", imem_addr, 32'h40);

    drive(0, 0, 0, 1, 32'd8, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("wait_addr0", imem_addr, 32'd8);
    drive(0, 0, 0, 1, 32'h20, 0);
    chk("wait_addr1", imem_addr, 32'd8);
    drive(0, 0, 0, 0, 0, 0);
    chk("wait_addr2", imem_addr, 32'd8);
    drive(0, 0, 0, 0, 0, 1);
    chk("wait_ready_addr", imem_addr, 32'd8);
    chk("wait_discard", 32'(if_valid), 32'd0);
    drive(0, 0, 0, 0, 0, 1);
    chk("wait_next_addr", imem_addr, 32'h20);

    drive(0, 0, 0, 1, 32'd10, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("hold_req_addr", imem_addr, 32'd10);
    drive(1, 0, 0, 0, 0, 1);
    chk("hold_enter_valid", 32'(if_valid), 32'd0);
    drive(1, 0, 0, 0, 0, 1);
    chk("hold_req", 32'(imem_req), 32'd0);
    drive(0, 0, 0, 0, 0, 1);
    chk("hold_out_valid", 32'(if_valid), 32'd1);
    chk("hold_out_pc", if_pc, 32'd10);
    drive(0, 0, 0, 0, 0, 1);
    chk("hold_resume", imem_addr, 32'd11);

    drive(0, 0, 0, 1, 32'hFFFF_FFFF, 1);
    drive(0, 0, 0, 0, 0, 1);
    chk("wrap_top", imem_addr, 32'hFFFF_FFFF);
    drive(0, 0, 0, 0, 0, 1);
    chk("wrap_zero", imem_addr, 32'd0);

    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_wait_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1);
    chk("rst_rel_req", 32'(imem_req), 32'd0);
    drive(0, 0, 0, 0, 0, 1);
    chk("rst_rel_addr", imem_addr, 32'd0);

    for (int n = 0; n < 4000; n++) begin
      logic [31:0] t1, t2;
      t1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom_range(0, 255);
      t2 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom_range(0, 255);
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk);
        rst = 1'b1;
      end else begin
        drive($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, t1,
              $urandom_range(0, 9) == 0, t2, $urandom_range(0, 9) < 7);
      end
    end

    @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
